// File: rtl/mapper_pkg.sv
// mapper_pkg -- shared definitions for the QAM mapper.
//   MAX_AXIS_BITS : widest supported axis index (64-QAM).
//   RESET_LEVEL   : level driven on the mapped outputs while in reset.
//   gray_to_bin() : Gray-code to natural-binary index conversion.
//   axis_level()  : axis index -> odd signed amplitude, 2k-(L-1).
package mapper_pkg;

  localparam int MAX_AXIS_BITS = 3;
  localparam int RESET_LEVEL   = -1;

  // Upper bits of a narrower index are zero-padded, and zeros above the
  // MSB leave the decode of the lower bits unchanged.
  function automatic logic [MAX_AXIS_BITS-1:0] gray_to_bin(
    input logic [MAX_AXIS_BITS-1:0] gray
  );
    logic [MAX_AXIS_BITS-1:0] bin;
    bin[MAX_AXIS_BITS-1] = gray[MAX_AXIS_BITS-1];
    for (int i = MAX_AXIS_BITS - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Levels are symmetric odd integers: -(L-1), ..., -1, +1, ..., +(L-1).
  function automatic int axis_level(
    input logic [MAX_AXIS_BITS-1:0] index,
    input int                       bits_per_axis
  );
    return 2 * int'(index) - ((1 << bits_per_axis) - 1);
  endfunction

endpackage

// File: rtl/qam_bit_collector.sv
// qam_bit_collector -- assembles serial MSB-first bits into one QAM symbol.
//   clock       : system clock, rising edge
//   i_reset     : asynchronous active-low reset
//   i_enable    : global enable; when low all state holds
//   i_valid     : i_bit qualifier
//   i_bit       : serial data bit
//   i_sync      : discards any partial symbol (wins over a completing bit)
//   o_symbol    : symbol including the bit on i_bit this cycle
//   o_complete  : high in the cycle whose accepted bit completes a symbol
module qam_bit_collector #(
  parameter int BITS_PER_AXIS = 1
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic                       i_bit,
  input  logic                       i_sync,
  output logic [2*BITS_PER_AXIS-1:0] o_symbol,
  output logic                       o_complete
);

  localparam int SYM_BITS = 2 * BITS_PER_AXIS;
  localparam int CNT_W    = $clog2(SYM_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_BITS - 1);

  logic [SYM_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]    count;
  logic                accept;

  assign accept     = i_enable & i_valid;
  assign o_symbol   = {shift_reg[SYM_BITS-2:0], i_bit};
  assign o_complete = accept & ~i_sync & (count == LAST);

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      shift_reg <= '0;
      count     <= '0;
    end else if (i_enable) begin
      if (i_sync) begin
        // A bit arriving with the strobe becomes bit 0 of the new symbol.
        shift_reg <= accept ? SYM_BITS'(i_bit) : '0;
        count     <= accept ? CNT_W'(1) : '0;
      end else if (i_valid) begin
        shift_reg <= o_symbol;
        count     <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/qam_mapper.sv
// qam_mapper -- serial bits to square-QAM I/Q levels (4/16/64-QAM).
//   clock       : system clock, rising edge
//   i_reset     : asynchronous active-low reset (outputs -> -1)
//   i_enable    : global enable
//   i_valid     : i_bit qualifier
//   i_bit       : serial data bit, MSB-first (I index first, then Q)
//   i_sync      : symbol-alignment strobe
//   o_mapped_i  : signed in-phase level, held between symbols
//   o_mapped_q  : signed quadrature level, held between symbols
//   o_valid     : one-cycle pulse when the levels update
// Build option: define QAM_MAPPER_GRAY_EN to Gray-decode each axis index
// before mapping; otherwise the natural binary index is used.
module qam_mapper
  import mapper_pkg::*;
#(
  parameter int BITS_PER_AXIS = 1,
  parameter int NB_OUT        = 4
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic                     i_bit,
  input  logic                     i_sync,
  output logic signed [NB_OUT-1:0] o_mapped_i,
  output logic signed [NB_OUT-1:0] o_mapped_q,
  output logic                     o_valid
);

  if (BITS_PER_AXIS < 1 || BITS_PER_AXIS > MAX_AXIS_BITS) begin : g_bad_bits
    $error("qam_mapper: BITS_PER_AXIS must be 1..3");
  end
  if (NB_OUT < BITS_PER_AXIS + 1) begin : g_bad_width
    $error("qam_mapper: NB_OUT too narrow for the level range");
  end

  logic [2*BITS_PER_AXIS-1:0] symbol;
  logic                       complete;
  logic [MAX_AXIS_BITS-1:0]   index_i;
  logic [MAX_AXIS_BITS-1:0]   index_q;
  logic signed [NB_OUT-1:0]   level_i;
  logic signed [NB_OUT-1:0]   level_q;

  qam_bit_collector #(
    .BITS_PER_AXIS (BITS_PER_AXIS)
  ) u_collector (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_bit      (i_bit),
    .i_sync     (i_sync),
    .o_symbol   (symbol),
    .o_complete (complete)
  );

`ifdef QAM_MAPPER_GRAY_EN
  assign index_i = gray_to_bin(MAX_AXIS_BITS'(symbol[2*BITS_PER_AXIS-1:BITS_PER_AXIS]));
  assign index_q = gray_to_bin(MAX_AXIS_BITS'(symbol[BITS_PER_AXIS-1:0]));
`else
  assign index_i = MAX_AXIS_BITS'(symbol[2*BITS_PER_AXIS-1:BITS_PER_AXIS]);
  assign index_q = MAX_AXIS_BITS'(symbol[BITS_PER_AXIS-1:0]);
`endif

  // Signed size cast sign-extends (or trims) the level to the port width.
  assign level_i = NB_OUT'(axis_level(index_i, BITS_PER_AXIS));
  assign level_q = NB_OUT'(axis_level(index_q, BITS_PER_AXIS));

  // complete already folds in i_enable and i_sync, so o_valid is a clean
  // single-cycle strobe and the levels hold otherwise.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_mapped_i <= NB_OUT'(RESET_LEVEL);
      o_mapped_q <= NB_OUT'(RESET_LEVEL);
      o_valid    <= 1'b0;
    end else begin
      o_valid <= complete;
      if (complete) begin
        o_mapped_i <= level_i;
        o_mapped_q <= level_q;
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper.sv
// tb_qam_mapper -- self-checking bench for qam_mapper.
// Three instances (4-, 16- and 64-QAM) share one stimulus stream; a
// behavioural model per instance predicts every output cycle by cycle.
module tb_qam_mapper;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic i_reset = 1'b1;
  logic i_enable, i_valid, i_bit, i_sync;

  logic signed [3:0] got_i [3];
  logic signed [3:0] got_q [3];
  logic              got_v [3];

  qam_mapper #(.BITS_PER_AXIS(1), .NB_OUT(4)) dut1 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .i_sync(i_sync),
    .o_mapped_i(got_i[0]), .o_mapped_q(got_q[0]), .o_valid(got_v[0]));

  qam_mapper #(.BITS_PER_AXIS(2), .NB_OUT(4)) dut2 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .i_sync(i_sync),
    .o_mapped_i(got_i[1]), .o_mapped_q(got_q[1]), .o_valid(got_v[1]));

  qam_mapper #(.BITS_PER_AXIS(3), .NB_OUT(4)) dut3 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_bit(i_bit), .i_sync(i_sync),
    .o_mapped_i(got_i[2]), .o_mapped_q(got_q[2]), .o_valid(got_v[2]));

`ifdef QAM_MAPPER_GRAY_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Gray decode as a running XOR of all right shifts.
  function automatic int gray_dec(input int g);
    int b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic int level_of(input int k, input int bpa);
    int kk = GRAY ? gray_dec(k) : k;
    return 2 * kk - ((1 << bpa) - 1);
  endfunction

  // ---------------- behavioural model ----------------
  int m_cnt [3] = '{0, 0, 0};
  int m_acc [3] = '{0, 0, 0};
  int exp_i [3] = '{-1, -1, -1};
  int exp_q [3] = '{-1, -1, -1};
  bit exp_v [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clock or negedge i_reset) begin
    int n, c, a, bpa;
    if (!i_reset) begin
      for (int d = 0; d < 3; d++) begin
        m_cnt[d] <= 0;
        m_acc[d] <= 0;
        exp_i[d] <= -1;
        exp_q[d] <= -1;
        exp_v[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        bpa = d + 1;
        n   = 2 * bpa;
        c   = m_cnt[d];
        a   = m_acc[d];
        exp_v[d] <= 1'b0;
        if (i_enable) begin
          if (i_sync) begin
            c = 0;
            a = 0;
          end
          if (i_valid) begin
            a = a * 2 + int'(i_bit);
            c = c + 1;
            if (c == n) begin
              exp_i[d] <= level_of(a >> bpa, bpa);
              exp_q[d] <= level_of(a & ((1 << bpa) - 1), bpa);
              exp_v[d] <= 1'b1;
              c = 0;
              a = 0;
            end
          end
        end
        m_cnt[d] <= c;
        m_acc[d] <= a;
      end
    end
  end

  // ---------------- compare process ----------------
  bit count_en = 1'b0;
  int pulses   = 0;
  int lvl_max  = -100;
  int lvl_min  = 100;

  always @(negedge clock) begin
    if (i_reset) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("dut%0d_valid", d + 1), int'(got_v[d]), int'(exp_v[d]));
        check($sformatf("dut%0d_i", d + 1), int'(got_i[d]), exp_i[d]);
        check($sformatf("dut%0d_q", d + 1), int'(got_q[d]), exp_q[d]);
      end
      if (count_en && got_v[2]) begin
        pulses++;
        if (int'(got_i[2]) > lvl_max) lvl_max = int'(got_i[2]);
        if (int'(got_q[2]) > lvl_max) lvl_max = int'(got_q[2]);
        if (int'(got_i[2]) < lvl_min) lvl_min = int'(got_i[2]);
        if (int'(got_q[2]) < lvl_min) lvl_min = int'(got_q[2]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit en, input bit v, input bit b, input bit s);
    @(negedge clock);
    i_enable = en;
    i_valid  = v;
    i_bit    = b;
    i_sync   = s;
  endtask

  task automatic send(input bit b);
    drive(1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sync_pulse();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_all_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_dut%0d_i", tag, d + 1), int'(got_i[d]), -1);
      check($sformatf("%s_dut%0d_q", tag, d + 1), int'(got_q[d]), -1);
      check($sformatf("%s_dut%0d_valid", tag, d + 1), int'(got_v[d]), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int accepted;
    bit v;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_bit    = 1'b0;
    i_sync   = 1'b0;

    #1 i_reset = 1'b0;
    #1 check_all_reset("reset");
    repeat (2) @(negedge clock);
    #2 i_reset = 1'b1;

    // 4-QAM: bits 0,1 -> I=-1, Q=+1, one-cycle strobe
    sync_pulse();
    send(1'b0); send(1'b1);
    idle(); #1;
    check("s1_i", int'(got_i[0]), -1);
    check("s1_q", int'(got_q[0]), 1);
    check("s1_valid", int'(got_v[0]), 1);
    @(posedge clock); #1;
    check("s1_valid_one_cycle", int'(got_v[0]), 0);

    // 16-QAM: bits 1,0,1,1
    sync_pulse();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    idle(); #1;
    check("s2_i", int'(got_i[1]), GRAY ? 3 : 1);
    check("s2_q", int'(got_q[1]), GRAY ? 1 : 3);
    check("s2_valid", int'(got_v[1]), 1);
    check("s2_4qam_i", int'(got_i[0]), 1);
    check("s2_4qam_q", int'(got_q[0]), 1);

    // sync discards a partial symbol
    sync_pulse();
    send(1'b1); send(1'b0);
    sync_pulse();
    send(1'b0); send(1'b0); send(1'b0);
    @(posedge clock); #1;
    check("s3_no_early_valid", int'(got_v[1]), 0);
    send(1'b0);
    idle(); #1;
    check("s3_i", int'(got_i[1]), -3);
    check("s3_q", int'(got_q[1]), -3);
    check("s3_valid", int'(got_v[1]), 1);

    // sync coinciding with the completing bit wins; that bit starts anew
    sync_pulse();
    send(1'b1); send(1'b0); send(1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clock); #1;
    check("sync_prec_no_valid", int'(got_v[1]), 0);
    send(1'b0); send(1'b0); send(1'b0);
    idle(); #1;
    check("sync_prec_i", int'(got_i[1]), -3);
    check("sync_prec_q", int'(got_q[1]), -3);
    check("sync_prec_valid", int'(got_v[1]), 1);

    // enable gap mid-symbol: everything ignored, outputs hold
    sync_pulse();
    send(1'b1); send(1'b0);
    repeat (5) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clock); #1;
      check("s4_gap_valid", int'(got_v[1]), 0);
      check("s4_gap_i_hold", int'(got_i[1]), -3);
    end
    send(1'b1); send(1'b1);
    idle(); #1;
    check("s4_i", int'(got_i[1]), GRAY ? 3 : 1);
    check("s4_q", int'(got_q[1]), GRAY ? 1 : 3);
    check("s4_valid", int'(got_v[1]), 1);

    // asynchronous reset between edges, while strobes are high
    sync_pulse();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b1); send(1'b0);
    @(posedge clock); #3;
    i_reset = 1'b0;
    i_valid = 1'b0;
    #1 check_all_reset("s5_async");
    @(negedge clock); #2;
    i_reset = 1'b1;
    send(1'b0); send(1'b1); send(1'b1); send(1'b0);
    idle(); #1;
    check("s5_i", int'(got_i[1]), -1);
    check("s5_q", int'(got_q[1]), GRAY ? 3 : 1);
    check("s5_valid", int'(got_v[1]), 1);
    check("s5_4qam_i", int'(got_i[0]), 1);
    check("s5_4qam_q", int'(got_q[0]), -1);

    // random mix of enable, valid, sync and data
    repeat (400) begin
      drive($urandom_range(0, 9) != 0, ($urandom % 4) != 0, 1'($urandom),
            $urandom_range(0, 29) == 0);
    end

    // 64-QAM: 1000 accepted random bits with valid gaps
    sync_pulse();
    @(posedge clock);
    count_en = 1'b1;
    accepted = 0;
    while (accepted < 1000) begin
      v = ($urandom % 4) != 0;
      drive(1'b1, v, 1'($urandom), 1'b0);
      if (v) accepted++;
    end
    @(negedge clock); #1;
    count_en = 1'b0;
    check("s6_pulses", pulses, 1000 / 6);
    check("s6_level_range", int'(lvl_max <= 7 && lvl_min >= -7), 1);

    idle();
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
